// File: rtl/vec_wb_arbiter.sv
// vec_wb_arbiter: three-way round-robin write-back arbiter feeding one registered output beat.
// Burst locking is compiled in only when VEC_WB_LOCK_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | output register empty, wb_valid = 0
// ST_FULL  | output register holds a beat, wb_valid = 1
module vec_wb_arbiter #(
    parameter int N = 8,
    parameter int M = 16,
    parameter int A = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 req_valid,
    output logic [2:0]                 req_ready,
    input  logic [2:0][A-1:0]          req_addr,
    input  logic [2:0][M-1:0][N-1:0]   req_data,
    input  logic [2:0]                 req_lock,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [1:0]                 wb_sel,
    output logic [A-1:0]               wb_addr,
    output logic [M-1:0][N-1:0]        wb_data,
    output logic [15:0]                wb_grant_cnt
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [1:0]              sel_q, sel_d;
    logic [A-1:0]            addr_q, addr_d;
    logic [M-1:0][N-1:0]     data_q, data_d;
    logic [15:0]             cnt_q, cnt_d;

    logic [2:0]              elig;
    logic [1:0]              start;
    logic [1:0]              win;
    logic [1:0]              win_next;
    logic                    any_valid;
    logic                    load;
    logic                    accept;

`ifdef VEC_WB_LOCK_EN
    logic                    locked_q, locked_d;
    logic [1:0]              owner_q, owner_d;

    // While locked only the owner may compete, even when it is idle.
    always_comb begin
        elig = req_valid;
        if (locked_q) begin
            elig = req_valid & (3'b001 << owner_q);
        end
    end
`else
    logic                    unused_lock;

    assign unused_lock = ^req_lock;

    always_comb begin
        elig = req_valid;
    end
`endif

    // An illegal pointer encoding arbitrates as 0 and is rewritten to 0.
    assign start     = (ptr_q > 2'd2) ? 2'd0 : ptr_q;
    assign any_valid = |elig;
    assign load      = (state_q == ST_EMPTY) | wb_ready;
    assign accept    = load & any_valid;
    assign win_next  = (win == 2'd2) ? 2'd0 : win + 2'd1;

    always_comb begin
        win = 2'd0;
        case (start)
            2'd1:    win = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
            2'd2:    win = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
            default: win = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        req_ready = 3'b000;
        if (accept) begin
            req_ready = 3'b001 << win;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = start;
        sel_d   = sel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef VEC_WB_LOCK_EN
        locked_d = locked_q;
        owner_d  = owner_q;
`endif
        if (load) begin
            if (accept) begin
                state_d = ST_FULL;
                sel_d   = win;
                addr_d  = req_addr[win];
                data_d  = req_data[win];
                cnt_d   = cnt_q + 16'd1;
`ifdef VEC_WB_LOCK_EN
                if (req_lock[win]) begin
                    locked_d = 1'b1;
                    owner_d  = win;
                end else begin
                    locked_d = 1'b0;
                    ptr_d    = win_next;
                end
`else
                ptr_d = win_next;
`endif
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= 2'd0;
            sel_q   <= 2'b00;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef VEC_WB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= 1'b0;
            owner_q  <= 2'd0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
        end
    end
`endif

    assign wb_valid     = (state_q == ST_FULL);
    assign wb_sel       = sel_q;
    assign wb_addr      = addr_q;
    assign wb_data      = data_q;
    assign wb_grant_cnt = cnt_q;

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Scoreboard bench for vec_wb_arbiter: a round-robin reference model predicts grants,
// a monitor checks every presented output beat against the expected queue.
module tb_vec_wb_arbiter;

    localparam int N = 8;
    localparam int M = 16;
    localparam int A = 4;

    typedef struct {
        logic [1:0]       sel;
        logic [A-1:0]     addr;
        logic [M*N-1:0]   data;
    } beat_t;

    logic                     clk;
    logic                     rst_n;
    logic [2:0]               req_valid;
    logic [2:0]               req_ready;
    logic [2:0][A-1:0]        req_addr;
    logic [2:0][M-1:0][N-1:0] req_data;
    logic [2:0]               req_lock;
    logic                     wb_valid;
    logic                     wb_ready;
    logic [1:0]               wb_sel;
    logic [A-1:0]             wb_addr;
    logic [M-1:0][N-1:0]      wb_data;
    logic [15:0]              wb_grant_cnt;

    int checks = 0;
    int errors = 0;

    beat_t      sb[$];
    logic [1:0] sel_log[$];

    logic        m_full;
    int          m_ptr;
    logic [15:0] m_cnt;
    logic        m_locked;
    int          m_owner;
    logic [2:0]  last_acc;

    vec_wb_arbiter #(.N(N), .M(M), .A(A)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_lock     (req_lock),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_sel       (wb_sel),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_grant_cnt (wb_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [M*N-1:0] act, input logic [M*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: a presented beat must equal the oldest predicted beat until it drains.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
                chk("wb_sel", wb_sel, sb[0].sel);
                chk("wb_addr", wb_addr, sb[0].addr);
                chk("wb_data", wb_data, sb[0].data);
                if (wb_ready) begin
                    sel_log.push_back(wb_sel);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic model_reset();
        m_full   = 1'b0;
        m_ptr    = 0;
        m_cnt    = 16'd0;
        m_locked = 1'b0;
        m_owner  = 0;
        last_acc = 3'b000;
        sb.delete();
        sel_log.delete();
    endtask

    // One clock: predict and check at the falling edge, then return just after the rising edge.
    task automatic step();
        int    w;
        int    idx;
        logic  ld;
        logic [2:0] exp_rdy;
        beat_t b;
        @(negedge clk);
        ld = !m_full || wb_ready;
        w  = -1;
        for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (w < 0 && req_valid[idx] && (!m_locked || idx == m_owner)) w = idx;
        end
        exp_rdy = (ld && w >= 0) ? (3'b001 << w) : 3'b000;
        chk("req_ready", req_ready, exp_rdy);
        chk("wb_valid_state", wb_valid, m_full);
        chk("grant_cnt", wb_grant_cnt, m_cnt);
        last_acc = exp_rdy;
        if (ld) begin
            if (w >= 0) begin
                b.sel  = w[1:0];
                b.addr = req_addr[w];
                b.data = req_data[w];
                sb.push_back(b);
                m_full = 1'b1;
                m_cnt  = m_cnt + 16'd1;
`ifdef VEC_WB_LOCK_EN
                if (req_lock[w]) begin
                    m_locked = 1'b1;
                    m_owner  = w;
                end else begin
                    m_locked = 1'b0;
                    m_ptr    = (w + 1) % 3;
                end
`else
                m_ptr = (w + 1) % 3;
`endif
            end else begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic new_beat(input int i);
        req_addr[i] = A'($urandom);
        req_data[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic logic seq_ok(input int n, input logic [1:0] e0, input logic [1:0] e1,
                                    input logic [1:0] e2, input logic [1:0] e3,
                                    input logic [1:0] e4, input logic [1:0] e5,
                                    input logic [1:0] e6);
        logic [1:0] e[7];
        e = '{e0, e1, e2, e3, e4, e5, e6};
        if (sel_log.size() != n) return 1'b0;
        for (int k = 0; k < n; k++) if (sel_log[k] !== e[k]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        int lk;
        rst_n     = 1'b0;
        req_valid = 3'b000;
        req_lock  = 3'b000;
        wb_ready  = 1'b0;
        for (int i = 0; i < 3; i++) new_beat(i);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_sel", wb_sel, 2'b00);
        chk("rst_wb_addr", wb_addr, '0);
        chk("rst_wb_data", wb_data, '0);
        chk("rst_grant_cnt", wb_grant_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round robin with everyone requesting.
        req_valid = 3'b111;
        wb_ready  = 1'b1;
        repeat (6) step();
        req_valid = 3'b000;
        repeat (2) step();
        chk("rr_sequence", seq_ok(6, 0, 1, 2, 0, 1, 2, 0), 1'b1);
        chk("rr_grant_cnt", wb_grant_cnt, 16'd6);

        // Single requester 1.
        req_valid   = 3'b010;
        req_addr[1] = 4'h3;
        req_data[1] = {M{8'hA5}};
        step();
        chk("single_valid", wb_valid, 1'b1);
        chk("single_sel", wb_sel, 2'b01);
        chk("single_addr", wb_addr, 4'h3);
        chk("single_data", wb_data, {M{8'hA5}});

        // Stall with all requesting, then release.
        wb_ready  = 1'b0;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) new_beat(i);
        repeat (4) step();
        wb_ready = 1'b1;
        step();
        chk("stall_release_grant", last_acc, 3'b100);

        // Randomised traffic with backpressure.
        for (int c = 0; c < 3000; c++) begin
            wb_ready = ($urandom_range(0, 3) != 0);
            step();
            for (int i = 0; i < 3; i++) begin
                if (last_acc[i] || !req_valid[i]) begin
                    req_valid[i] = $urandom_range(0, 1) != 0;
                    new_beat(i);
                end
            end
        end
        req_valid = 3'b000;
        wb_ready  = 1'b1;
        repeat (2) step();
        chk("drain_empty", wb_valid, 1'b0);

        // Asynchronous reset while a beat is held.
        req_valid = 3'b111;
        wb_ready  = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", wb_valid, 1'b0);
        chk("async_rst_cnt", wb_grant_cnt, 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        step();
        chk("post_rst_grant", last_acc, 3'b001);

`ifdef VEC_WB_LOCK_EN
        do_reset();
        req_valid = 3'b001;
        step();
        req_valid = 3'b010;
        step();
        req_valid = 3'b111;
        req_lock  = 3'b100;
        lk = 0;
        for (int c = 0; c < 20 && lk < 3; c++) begin
            step();
            if (last_acc[2]) begin
                lk++;
                req_lock[2] = (lk < 2);
                if (lk == 3) req_valid[2] = 1'b0;
                new_beat(2);
            end
        end
        chk("lock_beats_done", lk, 3);
        step();
        step();
        req_valid = 3'b000;
        repeat (2) step();
        chk("lock_sequence", seq_ok(7, 0, 1, 2, 2, 2, 0, 1), 1'b1);
`endif

        // Counter wrap.
        do_reset();
        req_lock  = 3'b000;
        req_valid = 3'b111;
        wb_ready  = 1'b1;
        repeat (65535) step();
        chk("cnt_ffff", wb_grant_cnt, 16'hFFFF);
        step();
        chk("cnt_wrap", wb_grant_cnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
